cnt_ring_n: RTL

- Parametrised successor to the fixed 4-bit ring counter: N-bit shift-register counter, selectable between ring (one-hot) and Johnson (twisted-ring) mode.
- Adds direction control, synchronous load by state index, binary index output, wrap pulse and self-correction from illegal codes.
- Used as a sequencer or phase generator for LED scanners, display multiplexing and stepper phases in the chapter-2 counter family.

---
 rtl/cnt_ring_pkg.sv | 40 ++++
 rtl/cnt_ring_decode.sv | 38 +++
 rtl/cnt_ring_n.sv | 102 ++++++++++
 3 files changed

// File: rtl/cnt_ring_pkg.sv
// Shared types and helpers for the ring/Johnson counter family.
// Codes are returned at CNT_MAX_N width; callers truncate to their own N.
package cnt_ring_pkg;

    typedef enum logic {
        RING    = 1'b0,
        JOHNSON = 1'b1
    } cnt_mode_e;

    localparam int CNT_DEF_N       = 4;
    localparam int CNT_DEF_JOHNSON = 0;
    localparam int CNT_MAX_N       = 32;

    typedef logic [CNT_MAX_N-1:0] cnt_code_t;

    function automatic int states_f(input int n, input cnt_mode_e mode);
        return (mode == JOHNSON) ? 2 * n : n;
    endfunction

    // Out-of-range indices map to state 0 so a bad load lands somewhere legal.
    function automatic cnt_code_t code_of_idx(input int idx, input int n, input cnt_mode_e mode);
        cnt_code_t code;
        int        k;
        code = '0;
        k    = (idx < 0 || idx >= states_f(n, mode)) ? 0 : idx;
        for (int b = 0; b < CNT_MAX_N; b++) begin
            if (b < n) begin
                if (mode == RING) begin
                    code[b] = (b == n - 1 - k);
                end else if (k <= n) begin
                    code[b] = (b >= n - k);
                end else begin
                    code[b] = (b < 2 * n - k);
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/cnt_ring_decode.sv
// Combinational decode of a ring/Johnson code into index, legality and idle.
// IDLE and illegal codes decode to index 0.
module cnt_ring_decode #(
    parameter int N       = 4,
    parameter int JOHNSON = 0,
    parameter int IW      = $clog2(2 * N)
) (
    input  logic [N-1:0]  q,
    output logic [IW-1:0] idx,
    output logic          legal,
    output logic          is_idle
);
    import cnt_ring_pkg::*;

    localparam cnt_mode_e MODE   = (JOHNSON != 0) ? cnt_ring_pkg::JOHNSON : cnt_ring_pkg::RING;
    localparam int        STATES = states_f(N, MODE);

    cnt_code_t q_wide;

    assign q_wide  = cnt_code_t'(q);
    assign is_idle = (MODE == RING) && (q == '0);

    // At most one code can match, so the last-match-wins loop is unambiguous.
    always_comb begin
        idx   = '0;
        legal = 1'b0;
        for (int k = 0; k < STATES; k++) begin
            if (q_wide == code_of_idx(k, N, MODE)) begin
                idx   = IW'(k);
                legal = 1'b1;
            end
        end
        if (is_idle) begin
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/cnt_ring_n.sv
// Parametrised ring / Johnson shift counter with direction, indexed load and wrap pulse.
// Optional sticky illegal-code flag 'err' when CNT_RING_ERR_EN is defined.
module cnt_ring_n #(
    parameter int N       = 4,
    parameter int JOHNSON = 0,
    parameter int IW      = $clog2(2 * N)
) (
    input  logic          Clk,
    input  logic          resetn,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    output logic [N-1:0]  q,
    output logic [IW-1:0] idx,
    output logic          wrap
`ifdef CNT_RING_ERR_EN
    ,
    output logic          err
`endif
);
    import cnt_ring_pkg::*;

    localparam cnt_mode_e      MODE     = (JOHNSON != 0) ? cnt_ring_pkg::JOHNSON : cnt_ring_pkg::RING;
    localparam int             STATES   = states_f(N, MODE);
    localparam logic [IW-1:0]  LAST     = IW'(STATES - 1);
    localparam logic [N-1:0]   Q_STATE0 = N'(code_of_idx(0, N, MODE));

    logic          legal;
    logic          is_idle;
    logic [N-1:0]  q_next;
    logic          wrap_next;
    logic [IW-1:0] step_idx;

    cnt_ring_decode #(
        .N       (N),
        .JOHNSON (JOHNSON),
        .IW      (IW)
    ) u_decode (
        .q       (q),
        .idx     (idx),
        .legal   (legal),
        .is_idle (is_idle)
    );

    // Stepping works on the decoded index and re-encodes, so both modes share one path.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        step_idx  = idx;
        if (!legal) begin
            q_next = Q_STATE0;
        end else if (load) begin
            q_next = N'(code_of_idx(int'(load_idx), N, MODE));
        end else if (en) begin
            if (is_idle) begin
                q_next = Q_STATE0;
            end else begin
                if (!dir) begin
                    if (idx == LAST) begin
                        step_idx  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        step_idx = idx + IW'(1);
                    end
                end else begin
                    if (idx == '0) begin
                        step_idx  = LAST;
                        wrap_next = 1'b1;
                    end else begin
                        step_idx = idx - IW'(1);
                    end
                end
                q_next = N'(code_of_idx(int'(step_idx), N, MODE));
            end
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

`ifdef CNT_RING_ERR_EN
    // Detection outranks load, so a simultaneous load cannot hide the event.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (!legal) begin
            err <= 1'b1;
        end else if (load) begin
            err <= 1'b0;
        end
    end
`endif

endmodule
